// File: rtl/inj_pkg.sv
// inj_pkg: register map, control/status bit positions, read sentinels and emit-state type (GAPW only with INJ_GAP_EN)
package inj_pkg;
  localparam logic [2:0] A_CTRL  = 3'b000;
  localparam logic [2:0] A_PORT1 = 3'b001;
  localparam logic [2:0] A_PORT2 = 3'b010;
  localparam logic [2:0] A_PORT3 = 3'b011;
  localparam logic [2:0] A_FILL1 = 3'b100;
  localparam logic [2:0] A_FILL2 = 3'b101;
  localparam logic [2:0] A_FILL3 = 3'b110;
  localparam logic [2:0] A_SENT  = 3'b111;
  localparam int B_GO    = 0;
  localparam int B_FLUSH = 1;
  localparam int B_OVF   = 7;
  localparam logic [7:0] RD_IDLE = 8'd251;
  localparam logic [7:0] RD_WO   = 8'd252;
`ifdef INJ_GAP_EN
  typedef enum logic [1:0] {E_IDLE, E_SEND, E_GAPW} emit_e;
`else
  typedef enum logic {E_IDLE, E_SEND} emit_e;
`endif
endpackage

// File: rtl/inj_fifo.sv
// inj_fifo: synchronous FIFO with flush; pushes while full and pops while empty are ignored
module inj_fifo #(
  parameter int DEPTH = 16,
  parameter int DW    = 8
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic                         flush_i,
  input  logic [DW-1:0]                din_i,
  output logic [DW-1:0]                dout_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic do_push, do_pop;
  assign full_o  = cnt_q == CW'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign dout_o  = mem_q[rd_q];
  assign count_o = cnt_q;
  // Storage: written only on an accepted push.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end
  // Pointers and occupancy; flush overrides any concurrent push or pop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= flush_i ? '0 : wr_q + AW'(do_push);
      rd_q  <= flush_i ? '0 : rd_q + AW'(do_pop);
      cnt_q <= flush_i ? '0 : cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/packet_injector.sv
// packet_injector: Avalon-MM loaded three-port byte injector, paced by ready; define INJ_GAP_EN for GAP idle cycles after each byte
module packet_injector
  import inj_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int GAP   = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       chipselect,
  input  logic       write,
  input  logic       read,
  input  logic [2:0] address,
  input  logic [7:0] writedata,
  output logic [7:0] readdata,
  output logic [7:0] data1,
  output logic [7:0] data2,
  output logic [7:0] data3,
  output logic       en1,
  output logic       en2,
  output logic       en3,
  input  logic       ready1,
  input  logic       ready2,
  input  logic       ready3
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [2:0] A_PORT [3] = '{A_PORT1, A_PORT2, A_PORT3};
  logic [2:0] ready, push, pop, full, empty, en;
  logic [7:0] head [3];
  logic [CW-1:0] fill [3];
  emit_e st_q [3];
  logic [7:0] data_q [3];
  logic go_q, ovf_q;
  logic [7:0] sent_q, rd_q, rd_d;
  logic bus_wr, ctrl_wr, flush;

  if (DEPTH < 2 || DEPTH > 128 || (DEPTH & (DEPTH - 1)) != 0 || GAP < 0) begin : g_bad_param
    $error("packet_injector: DEPTH must be a power of 2 in 2..128 and GAP must be non-negative");
  end

  assign ready   = {ready3, ready2, ready1};
  assign bus_wr  = chipselect && write;
  assign ctrl_wr = bus_wr && address == A_CTRL;
  assign flush   = ctrl_wr && writedata[B_FLUSH];

  for (genvar k = 0; k < 3; k++) begin : g_port
    assign push[k] = bus_wr && address == A_PORT[k] && |writedata;
    assign en[k]   = st_q[k] == E_SEND;
    inj_fifo #(.DEPTH(DEPTH), .DW(8)) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push_i  (push[k]),
      .pop_i   (pop[k]),
      .flush_i (flush),
      .din_i   (writedata),
      .dout_o  (head[k]),
      .full_o  (full[k]),
      .empty_o (empty[k]),
      .count_o (fill[k])
    );
  end

`ifdef INJ_GAP_EN
  localparam bit GAP_ON = GAP > 0;
  localparam int GW = GAP > 0 ? $clog2(GAP + 1) : 1;
  logic [GW-1:0] gap_q [3];
`endif

  // Launch decision per port: running, data queued, switch ready, and not cooling down.
  always_comb begin
    for (int k = 0; k < 3; k++) begin
`ifdef INJ_GAP_EN
      pop[k] = go_q && !empty[k] && ready[k] &&
               (st_q[k] == E_IDLE || (st_q[k] == E_SEND && !GAP_ON) ||
                (st_q[k] == E_GAPW && gap_q[k] == GW'(GAP)));
`else
      pop[k] = go_q && !empty[k] && ready[k];
`endif
    end
  end

  // Emit FSMs: register the popped head for a one-cycle en pulse, then optionally wait out the gap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < 3; k++) begin
        st_q[k]   <= E_IDLE;
        data_q[k] <= '0;
`ifdef INJ_GAP_EN
        gap_q[k]  <= '0;
`endif
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (pop[k]) begin
          st_q[k]   <= E_SEND;
          data_q[k] <= head[k];
`ifdef INJ_GAP_EN
        end else if (st_q[k] == E_SEND && GAP_ON) begin
          st_q[k]  <= E_GAPW;
          gap_q[k] <= GW'(1);
        end else if (st_q[k] == E_GAPW && gap_q[k] != GW'(GAP)) begin
          gap_q[k] <= gap_q[k] + 1'b1;
`endif
        end else begin
          st_q[k] <= E_IDLE;
        end
      end
    end
  end

  // Read mux: status, fill levels, emitted count; sentinels for write-only and no-read cycles.
  always_comb begin
    rd_d = RD_IDLE;
    if (chipselect && read) begin
      case (address)
        A_CTRL:  rd_d = {ovf_q, full, empty, go_q};
        A_FILL1: rd_d = 8'(fill[0]);
        A_FILL2: rd_d = 8'(fill[1]);
        A_FILL3: rd_d = 8'(fill[2]);
        A_SENT:  rd_d = sent_q;
        default: rd_d = RD_WO;
      endcase
    end
  end

  // GO, sticky overflow, emitted-byte counter and registered read data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      go_q   <= 1'b0;
      ovf_q  <= 1'b0;
      sent_q <= '0;
      rd_q   <= '0;
    end else begin
      go_q   <= ctrl_wr ? writedata[B_GO] : go_q;
      ovf_q  <= |(push & full) ? 1'b1 : (ctrl_wr && writedata[B_OVF]) ? 1'b0 : ovf_q;
      sent_q <= sent_q + 8'(en[0]) + 8'(en[1]) + 8'(en[2]);
      rd_q   <= rd_d;
    end
  end

  assign readdata = rd_q;
  assign data1    = data_q[0];
  assign data2    = data_q[1];
  assign data3    = data_q[2];
  assign en1      = en[0];
  assign en2      = en[1];
  assign en3      = en[2];
endmodule
